div_sequencer: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 39 +++
 rtl/div_sequencer.sv | 148 ++++++++++++++
 tb/tb_div_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared constants for the multi-cycle signed divider.
//               - DIV_WIDTH : default operand width
//               - S_IDLE / S_CALC / S_FIX : 2-bit controller state encoding
//               - DIV0_QUOT : quotient reported for a divide-by-zero
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // All-ones quotient on divide-by-zero; replicated to the operand width
    // by the user, so only one bit of it is ever consulted.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration on unsigned
//               magnitudes. {rem,quo} is shifted left by one, the divisor
//               magnitude is trial-subtracted from the widened remainder, and
//               the difference is kept when it does not borrow.
// Ports       : i_rem  [WIDTH-1:0]  partial remainder
//               i_quo  [WIDTH-1:0]  partial quotient / remaining dividend bits
//               i_dvs  [WIDTH-1:0]  divisor magnitude (non-zero)
//               o_rem  [WIDTH-1:0]  next partial remainder
//               o_quo  [WIDTH-1:0]  next partial quotient
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // The remainder is always below the divisor, so the shifted value fits in
    // WIDTH+1 bits and the top bit of the WIDTH+1-bit difference is the borrow.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, i_dvs};
    assign w_borrow  = w_diff[WIDTH];

    assign o_rem = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule : div_step
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle signed divider (truncating: quotient rounds
//               toward zero, remainder takes the dividend's sign). Operand
//               magnitudes are divided by a restoring shift-subtract datapath
//               over WIDTH cycles, then signs are applied in a fix-up cycle.
// Ports       : clk       system clock, rising edge
//               clr       synchronous active-high reset
//               start     request, only honoured while idle
//               dividend  [WIDTH-1:0] signed dividend, sampled on acceptance
//               divisor   [WIDTH-1:0] signed divisor, sampled on acceptance
//               busy      high while an operation is in flight
//               done      one-cycle pulse, z/dz valid from this cycle
//               dz        divide-by-zero flag of the last completed operation
//               z         [2*WIDTH-1:0] {remainder, quotient}, held
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               dz,
    output logic [2*WIDTH-1:0] z
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] c_last_iter  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_div0_quot  = {WIDTH{DIV0_QUOT[0]}};

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic [2*WIDTH-1:0] r_z;

    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Unsigned WIDTH-bit magnitudes: the most negative value maps onto its
    // own bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
    assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    // Sign fix-up. On divide-by-zero the dividend magnitude is still parked
    // in r_quo, so re-applying the dividend sign restores the original value.
    always_comb begin
        w_quo_fix = r_quo;
        w_rem_fix = r_rem;
        if (r_div0) begin
            w_quo_fix = c_div0_quot;
            w_rem_fix = r_neg_r ? ('0 - r_quo) : r_quo;
        end else begin
            w_quo_fix = r_neg_q ? ('0 - r_quo) : r_quo;
            w_rem_fix = r_neg_r ? ('0 - r_rem) : r_rem;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_z     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_quo   <= w_dvd_mag;
                        r_rem   <= '0;
                        r_dvs   <= w_dvs_mag;
                        r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r <= dividend[WIDTH-1];
                        r_div0  <= (divisor == '0);
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (divisor == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last_iter) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_z     <= {w_rem_fix, w_quo_fix};
                    r_dz    <= r_div0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign z    = r_z;

endmodule : div_sequencer
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer. Directed cases from
//               the block's behaviour plus randomized operands compared
//               against a plain-arithmetic truncating-division model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        dz;
    logic [63:0] z;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_sequencer #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .z        (z)
    );

    // Reference: {dz, remainder, quotient} from 64-bit signed arithmetic.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Waits for done, counting rising edges from the accepting edge
    // (start_edges edges have already elapsed), then checks the result.
    task automatic finish_op(input string tag, input logic [31:0] b, input int start_edges,
                             input logic [63:0] exp_z, input logic exp_dz);
        int edges;
        int bcyc;
        int exp_lat;
        edges   = start_edges;
        bcyc    = 0;
        exp_lat = (b == 32'd0) ? 2 : 34;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) bcyc++;
            @(negedge clk);
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(bcyc), 64'(exp_lat - start_edges));
        check({tag, " z"}, z, exp_z);
        check({tag, " dz"}, 64'(dz), 64'(exp_dz));
        check({tag, " busy in done cycle"}, 64'(busy), 64'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check({tag, " no extra done"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [64:0] m;
        logic [31:0] ra, rb;

        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dz", 64'(dz), 64'd0);
        check("reset z", z, 64'd0);
        clr = 1'b0;
        @(negedge clk);

        // Basic signed cases.
        launch(32'd7, 32'd2);
        finish_op("7/2", 32'd2, 1, {32'h0000_0001, 32'h0000_0003}, 1'b0);
        @(negedge clk);
        check("7/2 done drops", 64'(done), 64'd0);

        launch(-32'sd7, 32'd2);
        finish_op("-7/2", 32'd2, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        @(negedge clk);

        launch(32'd7, -32'sd2);
        finish_op("7/-2", -32'sd2, 1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
        @(negedge clk);

        // Divide by zero, then the overflow case clears dz.
        launch(32'd5, 32'd0);
        finish_op("5/0", 32'd0, 1, {32'h0000_0005, 32'hFFFF_FFFF}, 1'b1);
        repeat (4) @(negedge clk);
        check("5/0 dz held", 64'(dz), 64'd1);
        check("5/0 z held", z, {32'h0000_0005, 32'hFFFF_FFFF});

        launch(32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("ovf", 32'hFFFF_FFFF, 1, {32'h0000_0000, 32'h8000_0000}, 1'b0);
        @(negedge clk);

        // Reset on the 10th iteration edge discards the operation.
        launch(32'd100, 32'd3);
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort z", z, 64'd0);
        check("abort dz", 64'(dz), 64'd0);
        check("abort done", 64'(done), 64'd0);
        expect_quiet("abort", 40);

        launch(32'd100, 32'd3);
        finish_op("100/3", 32'd3, 1, {32'h0000_0001, 32'h0000_0021}, 1'b0);
        @(negedge clk);

        // A start pulse while busy is ignored.
        launch(32'd20, 32'd6);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd4;
        @(negedge clk);
        start    = 1'b0;
        finish_op("20/6 start-while-busy", 32'd6, 7, {32'd2, 32'd3}, 1'b0);
        expect_quiet("20/6", 40);

        // Back-to-back: start asserted in the done cycle is accepted.
        launch(32'd20, 32'd6);
        finish_op("20/6 first", 32'd6, 1, {32'd2, 32'd3}, 1'b0);
        launch(32'd9, 32'd4);
        finish_op("9/4 back-to-back", 32'd4, 1, {32'd1, 32'd2}, 1'b0);
        @(negedge clk);
        check("9/4 done drops", 64'(done), 64'd0);

        // Randomized operands, chained back-to-back.
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = -32'($urandom_range(1, 15));
                2: rb = 32'd0;
                3: begin ra = 32'h8000_0000; rb = (i % 2 == 0) ? 32'hFFFF_FFFF : rb; end
                4: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            m = model(ra, rb);
            launch(ra, rb);
            finish_op($sformatf("rand%0d %h/%h", i, ra, rb), rb, 1, m[63:0], m[64]);
        end
        @(negedge clk);
        check("final done drops", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_div_sequencer
`default_nettype wire
